// File: rtl/vx_warp_ibuffer_pkg.sv
// Shared types and defaults for the per-warp instruction buffer.
package vx_warp_ibuffer_pkg;

  localparam int IBUF_DEPTH = 2;
  localparam int IBUF_DATAW = 64;

  // One buffered decoded instruction (warp id is implied by the queue it sits in).
  typedef struct packed {
    logic [IBUF_DATAW-1:0] data;
  } ibuf_entry_t;

  // Pointer width; a 1-entry queue still needs a 1-bit pointer to be legal.
  function automatic int ibuf_ptr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/vx_ibuf_queue.sv
// Single-warp instruction FIFO: count, read/write pointers and payload storage.
module vx_ibuf_queue
  import vx_warp_ibuffer_pkg::*;
#(
  parameter int DEPTH = IBUF_DEPTH,
  parameter int DATAW = IBUF_DATAW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [DATAW-1:0] push_data,
  input  logic             pop,
  output logic [DATAW-1:0] head_data,
  output logic             valid,
  output logic             full,
  output logic             empty
);

  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int PTRW = ibuf_ptr_bits(DEPTH);

  logic [CNTW-1:0]  count_q, count_d;
  logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DATAW-1:0] mem_q [DEPTH];

  // Explicit compare-and-wrap so non-power-of-2 depths work.
  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  // Next-state for occupancy and pointers; simultaneous push/pop leaves count unchanged.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  // Occupancy and pointer registers, cleared by reset (queued entries are discarded).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Payload storage is not reset; validity comes from count alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign valid     = (count_q != '0);
  assign empty     = ~valid;
  assign full      = (count_q == CNTW'(DEPTH));
  assign head_data = mem_q[rd_ptr_q];

  // Simulation checks on occupancy invariants.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && full)) else $error("ibuf queue: push while full");
      assert (count_q <= CNTW'(DEPTH)) else $error("ibuf queue: count above depth");
    end
  end

endmodule

// File: rtl/vx_warp_ibuffer.sv
// Per-warp instruction buffer between decode and issue: steers by warp id into per-warp FIFOs.
module vx_warp_ibuffer
  import vx_warp_ibuffer_pkg::*;
#(
  parameter int  NUM_WARPS = 4,
  parameter int  DEPTH     = IBUF_DEPTH,
  parameter int  DATAW     = IBUF_DATAW,
  localparam int NW_BITS   = $clog2(NUM_WARPS)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       decode_valid,
  input  logic [NW_BITS-1:0]         decode_wid,
  input  logic [DATAW-1:0]           decode_data,
  output logic                       decode_ready,
  output logic [NUM_WARPS-1:0]       ibuf_valid,
  output logic [NUM_WARPS*DATAW-1:0] ibuf_data,
  input  logic [NUM_WARPS-1:0]       ibuf_ready,
  output logic [NUM_WARPS-1:0]       ibuf_pop,
  output logic [NUM_WARPS-1:0]       ibuf_empty
);

  logic [NUM_WARPS-1:0] push;
  logic [NUM_WARPS-1:0] pop;
  logic [NUM_WARPS-1:0] full;

  // Ready depends only on registered fullness of the addressed warp; a full warp
  // stays not-ready even if it pops this cycle.
  assign decode_ready = ~full[decode_wid];

  // Warp-id decode of the accepted instruction into a one-hot push.
  always_comb begin
    push = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      push[w] = decode_valid & decode_ready & (decode_wid == NW_BITS'(w));
    end
  end

  assign pop      = ibuf_valid & ibuf_ready;
  assign ibuf_pop = pop;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_queue
    vx_ibuf_queue #(
      .DEPTH (DEPTH),
      .DATAW (DATAW)
    ) u_queue (
      .clk       (clk),
      .rst_n     (reset_n),
      .push      (push[w]),
      .push_data (decode_data),
      .pop       (pop[w]),
      .head_data (ibuf_data[w*DATAW +: DATAW]),
      .valid     (ibuf_valid[w]),
      .full      (full[w]),
      .empty     (ibuf_empty[w])
    );
  end

  // Simulation check: the warp id must be known whenever an instruction is offered.
  always @(posedge clk) begin
    if (reset_n && decode_valid) begin
      assert (!$isunknown(decode_wid)) else $error("ibuf: X on decode_wid");
    end
  end

endmodule

// File: tb/tb_vx_warp_ibuffer.sv
// Self-checking bench for vx_warp_ibuffer (DEPTH=2 main instance, DEPTH=3 wrap instance).
module tb_vx_warp_ibuffer;

  logic         clk;
  logic         reset_n;
  logic         decode_valid;
  logic [1:0]   decode_wid;
  logic [63:0]  decode_data;
  logic         decode_ready;
  logic [3:0]   ibuf_valid;
  logic [255:0] ibuf_data;
  logic [3:0]   ibuf_ready;
  logic [3:0]   ibuf_pop;
  logic [3:0]   ibuf_empty;

  logic         dv3;
  logic         d3_ready;
  logic [3:0]   d3_valid;
  logic [255:0] d3_data;
  logic [3:0]   rdy3;
  logic [3:0]   d3_pop;
  logic [3:0]   d3_empty;

  int checks;
  int errors;

  // reference model: one queue per warp for the DEPTH=2 instance
  logic [63:0] mq [4][$];

  vx_warp_ibuffer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .decode_valid (decode_valid),
    .decode_wid   (decode_wid),
    .decode_data  (decode_data),
    .decode_ready (decode_ready),
    .ibuf_valid   (ibuf_valid),
    .ibuf_data    (ibuf_data),
    .ibuf_ready   (ibuf_ready),
    .ibuf_pop     (ibuf_pop),
    .ibuf_empty   (ibuf_empty)
  );

  vx_warp_ibuffer #(.DEPTH(3)) dut3 (
    .clk          (clk),
    .reset_n      (reset_n),
    .decode_valid (dv3),
    .decode_wid   (decode_wid),
    .decode_data  (decode_data),
    .decode_ready (d3_ready),
    .ibuf_valid   (d3_valid),
    .ibuf_data    (d3_data),
    .ibuf_ready   (rdy3),
    .ibuf_pop     (d3_pop),
    .ibuf_empty   (d3_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] m_valid();
    logic [3:0] v;
    v = '0;
    for (int w = 0; w < 4; w++) v[w] = (mq[w].size() != 0);
    return v;
  endfunction

  // drive inputs just after a rising edge and move to the falling edge for sampling
  task automatic apply(input logic dv, input logic [1:0] wid, input logic [63:0] data,
                       input logic [3:0] rdy);
    decode_valid = dv;
    decode_wid   = wid;
    decode_data  = data;
    ibuf_ready   = rdy;
    #4;
  endtask

  // advance the model by the transfer that happens at the coming rising edge
  task automatic tick();
    logic acc;
    logic [63:0] junk;
    acc = decode_valid && (mq[decode_wid].size() < 2);
    for (int w = 0; w < 4; w++)
      if (ibuf_ready[w] && mq[w].size() != 0) junk = mq[w].pop_front();
    if (acc) mq[decode_wid].push_back(decode_data);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    decode_valid = 0; decode_wid = 0; decode_data = '0; ibuf_ready = '0;
    dv3 = 0; rdy3 = '0;
    reset_n = 0;
    for (int w = 0; w < 4; w++) mq[w].delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
  endtask

  task automatic test_reset();
    apply(0, 0, '0, '0);
    checks++; if (ibuf_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b expected 0000", ibuf_valid); end
    checks++; if (ibuf_empty !== 4'b1111) begin errors++; $display("FAIL reset_empty: got %b expected 1111", ibuf_empty); end
    checks++; if (ibuf_pop !== 4'b0000) begin errors++; $display("FAIL reset_pop: got %b expected 0000", ibuf_pop); end
    checks++; if (decode_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", decode_ready); end
    checks++; if (d3_empty !== 4'b1111 || d3_ready !== 1'b1) begin errors++; $display("FAIL reset_d3: got empty %b ready %b expected 1111 1", d3_empty, d3_ready); end
    tick();
  endtask

  task automatic test_fill_wid1();
    apply(1, 1, 64'hA, 4'b0000);
    checks++; if (decode_ready !== 1'b1 || ibuf_valid !== 4'b0000) begin errors++; $display("FAIL fill_first: got ready %b valid %b expected 1 0000", decode_ready, ibuf_valid); end
    tick();
    apply(1, 1, 64'hB, 4'b0000);
    checks++; if (ibuf_valid !== 4'b0010) begin errors++; $display("FAIL fill_valid: got %b expected 0010", ibuf_valid); end
    checks++; if (ibuf_data[64 +: 64] !== 64'hA) begin errors++; $display("FAIL fill_head: got %h expected a", ibuf_data[64 +: 64]); end
    tick();
    apply(1, 1, 64'hC, 4'b0000);
    checks++; if (decode_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready: got %b expected 0", decode_ready); end
    checks++; if (ibuf_empty !== 4'b1101) begin errors++; $display("FAIL fill_empty: got %b expected 1101", ibuf_empty); end
    tick();
  endtask

  task automatic test_full_pop();
    apply(1, 1, 64'hC, 4'b0010);
    checks++; if (ibuf_pop !== 4'b0010) begin errors++; $display("FAIL fullpop_pulse: got %b expected 0010", ibuf_pop); end
    checks++; if (decode_ready !== 1'b0) begin errors++; $display("FAIL fullpop_noready: got %b expected 0", decode_ready); end
    tick();
    apply(1, 1, 64'hC, 4'b0000);
    checks++; if (decode_ready !== 1'b1) begin errors++; $display("FAIL fullpop_ready_next: got %b expected 1", decode_ready); end
    checks++; if (ibuf_data[64 +: 64] !== 64'hB) begin errors++; $display("FAIL fullpop_head_b: got %h expected b", ibuf_data[64 +: 64]); end
    tick();
    apply(0, 0, '0, 4'b0010);
    checks++; if (ibuf_data[64 +: 64] !== 64'hB || ibuf_pop !== 4'b0010) begin errors++; $display("FAIL fullpop_pop_b: got %h pop %b expected b 0010", ibuf_data[64 +: 64], ibuf_pop); end
    tick();
    apply(0, 0, '0, 4'b0010);
    checks++; if (ibuf_data[64 +: 64] !== 64'hC) begin errors++; $display("FAIL fullpop_head_c: got %h expected c", ibuf_data[64 +: 64]); end
    tick();
    apply(0, 0, '0, 4'b0000);
    checks++; if (ibuf_empty !== 4'b1111) begin errors++; $display("FAIL fullpop_drained: got %b expected 1111", ibuf_empty); end
    tick();
  endtask

  task automatic test_interleave();
    logic [3:0] exp_v;
    for (int w = 0; w < 4; w++) begin
      apply(1, 2'(w), 64'h1000 + 64'(w), 4'b1111);
      exp_v = (w == 0) ? 4'b0000 : 4'(1 << (w - 1));
      checks++; if (ibuf_valid !== exp_v || ibuf_pop !== exp_v) begin errors++; $display("FAIL interleave_valid w%0d: got valid %b pop %b expected %b", w, ibuf_valid, ibuf_pop, exp_v); end
      if (w > 0) begin
        checks++; if (ibuf_data[(w-1)*64 +: 64] !== 64'h1000 + 64'(w - 1)) begin errors++; $display("FAIL interleave_data w%0d: got %h expected %h", w - 1, ibuf_data[(w-1)*64 +: 64], 64'h1000 + 64'(w - 1)); end
      end
      tick();
    end
    apply(0, 0, '0, 4'b1111);
    checks++; if (ibuf_valid !== 4'b1000 || ibuf_data[192 +: 64] !== 64'h1003) begin errors++; $display("FAIL interleave_last: got valid %b data %h expected 1000 1003", ibuf_valid, ibuf_data[192 +: 64]); end
    tick();
    apply(0, 0, '0, 4'b0000);
    checks++; if (ibuf_valid !== 4'b0000) begin errors++; $display("FAIL interleave_drained: got %b expected 0000", ibuf_valid); end
    tick();
  endtask

  task automatic test_same_cycle();
    apply(1, 2, 64'h2222_0001, 4'b0000);
    tick();
    apply(1, 2, 64'h2222_0002, 4'b0100);
    checks++; if (ibuf_pop !== 4'b0100 || decode_ready !== 1'b1) begin errors++; $display("FAIL same_pop: got pop %b ready %b expected 0100 1", ibuf_pop, decode_ready); end
    checks++; if (ibuf_data[128 +: 64] !== 64'h2222_0001) begin errors++; $display("FAIL same_head_old: got %h expected 22220001", ibuf_data[128 +: 64]); end
    tick();
    apply(0, 0, '0, 4'b0000);
    checks++; if (ibuf_valid !== 4'b0100 || ibuf_pop !== 4'b0000) begin errors++; $display("FAIL same_count: got valid %b pop %b expected 0100 0000", ibuf_valid, ibuf_pop); end
    checks++; if (ibuf_data[128 +: 64] !== 64'h2222_0002) begin errors++; $display("FAIL same_head_new: got %h expected 22220002", ibuf_data[128 +: 64]); end
    tick();
    apply(0, 0, '0, 4'b0100);
    tick();
  endtask

  task automatic test_random();
    logic [3:0] ev;
    for (int n = 0; n < 400; n++) begin
      apply($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), {$urandom, $urandom},
            4'($urandom & $urandom));
      ev = m_valid();
      checks++; if (decode_ready !== (mq[decode_wid].size() < 2)) begin errors++; $display("FAIL rand_ready n%0d: got %b expected %b", n, decode_ready, mq[decode_wid].size() < 2); end
      checks++; if (ibuf_valid !== ev || ibuf_empty !== ~ev) begin errors++; $display("FAIL rand_valid n%0d: got %b/%b expected %b", n, ibuf_valid, ibuf_empty, ev); end
      checks++; if (ibuf_pop !== (ev & ibuf_ready)) begin errors++; $display("FAIL rand_pop n%0d: got %b expected %b", n, ibuf_pop, ev & ibuf_ready); end
      for (int w = 0; w < 4; w++) begin
        if (mq[w].size() != 0) begin
          checks++; if (ibuf_data[w*64 +: 64] !== mq[w][0]) begin errors++; $display("FAIL rand_data n%0d w%0d: got %h expected %h", n, w, ibuf_data[w*64 +: 64], mq[w][0]); end
        end
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 2; k++) begin
        apply(1, 2'(w), 64'h5000 + 64'(w * 2 + k), 4'b0000);
        tick();
      end
    end
    apply(0, 0, '0, 4'b1111);
    checks++; if (ibuf_pop !== 4'b1111) begin errors++; $display("FAIL areset_pre_pop: got %b expected 1111", ibuf_pop); end
    #2;
    reset_n = 0;
    for (int w = 0; w < 4; w++) mq[w].delete();
    #1;
    checks++; if (ibuf_valid !== 4'b0000 || ibuf_pop !== 4'b0000) begin errors++; $display("FAIL areset_outputs: got valid %b pop %b expected 0000 0000", ibuf_valid, ibuf_pop); end
    checks++; if (ibuf_empty !== 4'b1111) begin errors++; $display("FAIL areset_empty: got %b expected 1111", ibuf_empty); end
    ibuf_ready = '0;
    @(posedge clk);
    #1;
    reset_n = 1;
    for (int w = 0; w < 4; w++) begin
      apply(0, 2'(w), '0, 4'b0000);
      checks++; if (decode_ready !== 1'b1) begin errors++; $display("FAIL areset_ready w%0d: got %b expected 1", w, decode_ready); end
      tick();
    end
  endtask

  task automatic test_wrap_depth3();
    logic [63:0] q3 [$];
    logic [63:0] junk;
    logic acc;
    int pushed;
    int popped;
    pushed = 0;
    popped = 0;
    decode_valid = 0;
    ibuf_ready = '0;
    for (int k = 0; k < 20 && popped < 5; k++) begin
      dv3         = (pushed < 5);
      decode_wid  = 0;
      decode_data = 64'h300 + 64'(pushed);
      rdy3        = (k >= 3) ? 4'b0001 : 4'b0000;
      #4;
      checks++; if (d3_ready !== (q3.size() < 3)) begin errors++; $display("FAIL wrap_ready k%0d: got %b expected %b", k, d3_ready, q3.size() < 3); end
      checks++; if (d3_valid[0] !== (q3.size() != 0) || d3_pop[0] !== (rdy3[0] && q3.size() != 0)) begin errors++; $display("FAIL wrap_valid k%0d: got valid %b pop %b", k, d3_valid[0], d3_pop[0]); end
      if (q3.size() != 0) begin
        checks++; if (d3_data[63:0] !== q3[0]) begin errors++; $display("FAIL wrap_data k%0d: got %h expected %h", k, d3_data[63:0], q3[0]); end
      end
      acc = dv3 && (q3.size() < 3);
      if (rdy3[0] && q3.size() != 0) begin junk = q3.pop_front(); popped++; end
      if (acc) begin q3.push_back(decode_data); pushed++; end
      @(posedge clk);
      #1;
    end
    dv3 = 0;
    rdy3 = '0;
    #4;
    checks++; if (d3_empty !== 4'b1111 || popped != 5) begin errors++; $display("FAIL wrap_done: got empty %b popped %0d expected 1111 5", d3_empty, popped); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    do_reset();
    test_reset();
    test_fill_wid1();
    test_full_pop();
    test_interleave();
    test_same_cycle();
    test_random();
    test_async_reset();
    test_wrap_depth3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vx_warp_ibuffer.md
Name: vx_warp_ibuffer

Overview:
- Per-warp instruction buffer directly downstream of the decode stage.
- Accepts one decoded instruction per cycle over the decode valid/ready handshake and steers it by warp id into a small per-warp FIFO.
- Presents one head instruction per warp to the scoreboard/issue stage.
- Returns a per-warp ibuf_pop pulse to the fetch/scheduler so it can credit in-flight instructions per warp.

Parameters:
- NUM_WARPS, 4, number of warps; one queue each; must be a power of 2, >= 2.
- DEPTH, 2, entries per warp queue; >= 2.
- DATAW, 64, width of the decoded-instruction payload excluding wid.
- NW_BITS, clog2(NUM_WARPS), warp-id width (derived, not overridable).

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous, active-low reset.
- decode_valid  input  1  decoded instruction valid.
- decode_wid  input  NW_BITS  warp id of decoded instruction.
- decode_data  input  DATAW  decoded payload.
- decode_ready  output  1  buffer accepts the instruction this cycle.
- ibuf_valid  output  NUM_WARPS  head of warp w's queue valid.
- ibuf_data  output  NUM_WARPS*DATAW  head payload per warp; warp w at [w*DATAW +: DATAW].
- ibuf_ready  input  NUM_WARPS  consumer takes warp w's head.
- ibuf_pop  output  NUM_WARPS  one-cycle pulse per instruction leaving warp w's queue.
- ibuf_empty  output  NUM_WARPS  warp w queue holds zero entries (for barrier/idle logic).

Behaviour:
- Reset (reset_n low, async assert, sync deassert handled upstream): all counts 0, read/write pointers 0, ibuf_valid=0, ibuf_pop=0, ibuf_empty=all 1s. decode_ready reflects count 0 (=1). Payload storage is not reset.
- Per-warp state: count[w] (clog2(DEPTH+1) bits), rd_ptr[w] and wr_ptr[w] (clog2(DEPTH) bits). Pointers wrap from DEPTH-1 to 0; non-power-of-2 DEPTH uses an explicit compare-and-wrap.
- full[w] = (count[w]==DEPTH). decode_ready = ~full[decode_wid]. It is combinational from registered state and decode_wid only, never from decode_valid or ibuf_ready.
- push[w] = decode_valid & decode_ready & (decode_wid==w). On push: write payload at wr_ptr[w]; the entry is visible at ibuf_data the next cycle. Push-to-valid latency is 1 cycle.
- ibuf_valid[w] = (count[w]!=0). ibuf_data[w] = entry at rd_ptr[w], combinational read of registered storage.
- pop[w] = ibuf_valid[w] & ibuf_ready[w]. ibuf_pop[w] = pop[w] in the same cycle (combinational).
- Count update: push only → +1; pop only → -1; push and pop on the same warp → unchanged, both pointers advance.
- Full warp with a simultaneous pop: decode_ready is still 0 that cycle; no bypass. The push succeeds the following cycle.
- Empty warp with a simultaneous push: no pass-through. ibuf_valid rises the next cycle.
- Only one warp can be pushed per cycle; any number of warps can pop in the same cycle.
- ibuf_data and ibuf_valid must hold stable while ibuf_valid=1 and ibuf_ready=0.
- decode_valid held with decode_ready=0: nothing is written; the instruction is held upstream.
- Reset mid-operation: all queued instructions are discarded and ibuf_pop is 0 during reset.
- Assertions (sim only): no push when full; count never exceeds DEPTH; no X on decode_wid when decode_valid=1.

Decomposition:
- VX_gpu_pkg gains: ibuf entry typedef (payload struct) and the IBUF_DEPTH default constant.
- Sub-module vx_ibuf_queue: one single-warp FIFO with count, pointers, storage, and push/pop/full/empty. It is instantiated NUM_WARPS times in a generate loop.
- The top level holds only wid decode, ready mux, and pop/pulse wiring.

Test Plan:
- After reset, push 2 instructions to wid=1 (payloads 0xA, 0xB) with ibuf_ready=0 → ibuf_valid=4'b0010 from the cycle after the first push; then decode_ready=0 for wid=1; ibuf_empty=4'b1101.
- Continuing from the wid=1-full state, assert ibuf_ready[1] for 1 cycle while decode_valid presents wid=1 payload 0xC → ibuf_pop=4'b0010 that cycle; decode_ready=0 that cycle; push of 0xC accepted the next cycle; head becomes 0xB, then 0xC.
- Interleave wid 0,1,2,3 pushes with ibuf_ready=4'b1111 held → each warp shows valid 1 cycle after its push, pops immediately, and per-warp order is preserved; no cross-warp corruption.
- Queue of wid=2 holds 1 entry; push and pop wid=2 in the same cycle → count stays 1; head advances to the new payload next cycle; ibuf_pop[2]=1 once.
- Fill all warps, then drop reset_n asynchronously mid-cycle → ibuf_valid=0, ibuf_pop=0, ibuf_empty=4'b1111 immediately; decode_ready=1 after release.
- DEPTH=3 build: push 5 and pop 5 on wid=0 → pointers wrap 2→0 and payloads come out in order.
